// File: rtl/spi_input_frontend.sv
// Conditions the raw SPI pins into the clk domain (two-flop sync plus debounce),
// derives sClk edge pulses and tracks the bit position within each frame.
module spi_input_frontend #(
  parameter int waitTime      = 3,
  parameter int counterWidth  = 3,
  parameter int frameBits     = 8,
  parameter int bitCountWidth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclkPin,
  input  logic                     csPin,
  input  logic                     mosiPin,
  output logic                     sClkConditioned,
  output logic                     sClkPosEdge,
  output logic                     sClkNegEdge,
  output logic                     chipSelectConditioned,
  output logic                     mosiConditioned,
  output logic [bitCountWidth-1:0] bitCount,
  output logic                     frameDone
);

  localparam int SclkIdx = 0;
  localparam int CsIdx   = 1;
  localparam int MosiIdx = 2;

  // Channel bit order is {mosi, cs, sclk}; cs idles high so its flops reset to 1.
  localparam logic [2:0] ResetLevel = 3'b010;

  localparam logic [counterWidth-1:0]  WaitCount = counterWidth'(waitTime);
  localparam logic [bitCountWidth-1:0] LastBit   = bitCountWidth'(frameBits - 1);

  logic [2:0]              r_sync0;
  logic [2:0]              r_sync1;
  logic [2:0]              r_cond;
  logic [counterWidth-1:0] r_cnt [3];
  logic                    r_sClkPosEdge;
  logic                    r_sClkNegEdge;
  logic [bitCountWidth-1:0] r_bitCount;
  logic                    r_frameDone;
  logic [2:0]              w_pins;

  assign w_pins = {mosiPin, csPin, sclkPin};

  // Edge pulses live here so they line up with the new sClkConditioned value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0       <= ResetLevel;
      r_sync1       <= ResetLevel;
      r_cond        <= ResetLevel;
      r_sClkPosEdge <= 1'b0;
      r_sClkNegEdge <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0       <= w_pins;
      r_sync1       <= r_sync0;
      r_sClkPosEdge <= 1'b0;
      r_sClkNegEdge <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (r_sync1[i] == r_cond[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == WaitCount) begin
          r_cond[i] <= r_sync1[i];
          r_cnt[i]  <= '0;
          if (i == SclkIdx) begin
            r_sClkPosEdge <= r_sync1[i];
            r_sClkNegEdge <= ~r_sync1[i];
          end
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Chip select inactive overrides any coincident sClk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitCount  <= '0;
      r_frameDone <= 1'b0;
    end else if (r_cond[CsIdx]) begin
      r_bitCount  <= '0;
      r_frameDone <= 1'b0;
    end else if (r_sClkPosEdge && (r_bitCount == LastBit)) begin
      r_bitCount  <= '0;
      r_frameDone <= 1'b1;
    end else if (r_sClkPosEdge) begin
      r_bitCount  <= r_bitCount + 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
    end
  end

  assign sClkConditioned       = r_cond[SclkIdx];
  assign chipSelectConditioned = r_cond[CsIdx];
  assign mosiConditioned       = r_cond[MosiIdx];
  assign sClkPosEdge           = r_sClkPosEdge;
  assign sClkNegEdge           = r_sClkNegEdge;
  assign bitCount              = r_bitCount;
  assign frameDone             = r_frameDone;

endmodule

// File: tb/tb_spi_input_frontend.sv
// Directed bench for spi_input_frontend: reset, debounce latency, glitch
// rejection, frame counting, aborts, coincident events and mid-frame reset.
module tb_spi_input_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclkPin;
  logic       csPin;
  logic       mosiPin;
  logic       sClkConditioned;
  logic       sClkPosEdge;
  logic       sClkNegEdge;
  logic       chipSelectConditioned;
  logic       mosiConditioned;
  logic [3:0] bitCount;
  logic       frameDone;

  int assertCount = 0;
  int failCount   = 0;
  int bothCount   = 0;

  spi_input_frontend dut (
    .clk                  (clk),
    .reset                (reset),
    .sclkPin              (sclkPin),
    .csPin                (csPin),
    .mosiPin              (mosiPin),
    .sClkConditioned      (sClkConditioned),
    .sClkPosEdge          (sClkPosEdge),
    .sClkNegEdge          (sClkNegEdge),
    .chipSelectConditioned(chipSelectConditioned),
    .mosiConditioned      (mosiConditioned),
    .bitCount             (bitCount),
    .frameDone            (frameDone)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sClkPosEdge && sClkNegEdge) bothCount++;
  endtask

  // One sclk period: 10 clk high then 10 clk low, recording what the DUT emitted.
  task automatic sclkPeriod(output int posCnt, output int negCnt, output int fdCnt,
                            output int posIdx, output int fdIdx);
    posCnt = 0; negCnt = 0; fdCnt = 0; posIdx = -1; fdIdx = -1;
    sclkPin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) sclkPin = 1'b0;
      tick();
      if (sClkPosEdge) begin posCnt++; posIdx = i; end
      if (sClkNegEdge) negCnt++;
      if (frameDone) begin fdCnt++; fdIdx = i; end
    end
  endtask

  task automatic csSettle(input logic level);
    csPin = level;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sclkPin = 1'b0; csPin = 1'b0; mosiPin = 1'b0;
    repeat (2) tick();
    assertCount++;
    if ({sClkConditioned, sClkPosEdge, sClkNegEdge, chipSelectConditioned,
         mosiConditioned, bitCount, frameDone} !== 10'b0001_0_0000_0) begin
      failCount++;
      $display("[TB] FAIL reset_values: got sc=%b pe=%b ne=%b cs=%b mo=%b bc=%0d fd=%b, need cs=1 rest 0",
               sClkConditioned, sClkPosEdge, sClkNegEdge, chipSelectConditioned,
               mosiConditioned, bitCount, frameDone);
    end
    reset = 1'b0; csPin = 1'b1;
    repeat (8) tick();
    assertCount++;
    if ({sClkConditioned, sClkPosEdge, sClkNegEdge, chipSelectConditioned,
         mosiConditioned, bitCount, frameDone} !== 10'b0001_0_0000_0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: got sc=%b pe=%b ne=%b cs=%b mo=%b bc=%0d fd=%b, need cs=1 rest 0",
               sClkConditioned, sClkPosEdge, sClkNegEdge, chipSelectConditioned,
               mosiConditioned, bitCount, frameDone);
    end
  endtask

  task automatic test_latency();
    for (int dir = 1; dir >= 0; dir--) begin
      sclkPin = dir[0];
      for (int e = 1; e <= 7; e++) begin
        tick();
        assertCount++;
        if (sClkConditioned !== ((e >= 6) ? dir[0] : ~dir[0]) ||
            sClkPosEdge !== ((e == 6) && dir == 1) ||
            sClkNegEdge !== ((e == 6) && dir == 0)) begin
          failCount++;
          $display("[TB] FAIL latency dir=%0d edge=%0d: got sc=%b pe=%b ne=%b", dir, e,
                   sClkConditioned, sClkPosEdge, sClkNegEdge);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int highCnt;
    highCnt = 0;
    mosiPin = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) mosiPin = 1'b0;
      tick();
      if (mosiConditioned) highCnt++;
    end
    assertCount++;
    if (highCnt !== 0) begin
      failCount++;
      $display("[TB] FAIL glitch_short: mosi high for %0d cycles, need 0", highCnt);
    end
    highCnt = 0;
    mosiPin = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) mosiPin = 1'b0;
      tick();
      if (mosiConditioned) highCnt++;
    end
    assertCount++;
    if (highCnt !== 10) begin
      failCount++;
      $display("[TB] FAIL glitch_long: mosi high for %0d cycles, need 10", highCnt);
    end
  endtask

  task automatic test_full_frame();
    int pc, nc, fc, pi, fi;
    csSettle(1'b0);
    assertCount++;
    if (chipSelectConditioned !== 1'b0 || bitCount !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL frame_cs_active: got cs=%b bc=%0d, need cs=0 bc=0",
               chipSelectConditioned, bitCount);
    end
    for (int k = 1; k <= 9; k++) begin
      sclkPeriod(pc, nc, fc, pi, fi);
      assertCount++;
      if (bitCount !== 4'(k % 8) || pc != 1 || nc != 1 || fc != ((k == 8) ? 1 : 0)) begin
        failCount++;
        $display("[TB] FAIL frame_period %0d: got bc=%0d pos=%0d neg=%0d fd=%0d, need bc=%0d pos=1 neg=1 fd=%0d",
                 k, bitCount, pc, nc, fc, k % 8, (k == 8) ? 1 : 0);
      end
      if (k == 8) begin
        assertCount++;
        if (fi != pi + 1) begin
          failCount++;
          $display("[TB] FAIL frame_done_timing: frameDone at %0d, posEdge at %0d, need one cycle later",
                   fi, pi);
        end
      end
    end
  endtask

  task automatic test_abort();
    int pc, nc, fc, pi, fi, fdSeen;
    csSettle(1'b1);
    repeat (2) tick();
    csSettle(1'b0);
    for (int k = 0; k < 5; k++) sclkPeriod(pc, nc, fc, pi, fi);
    assertCount++;
    if (bitCount !== 4'd5) begin
      failCount++;
      $display("[TB] FAIL abort_partial: got bc=%0d, need 5", bitCount);
    end
    fdSeen = 0;
    csPin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frameDone) fdSeen++;
    end
    assertCount++;
    if (bitCount !== 4'd0 || chipSelectConditioned !== 1'b1 || fdSeen != 0) begin
      failCount++;
      $display("[TB] FAIL abort_clear: got bc=%0d cs=%b fd=%0d, need bc=0 cs=1 fd=0",
               bitCount, chipSelectConditioned, fdSeen);
    end
    csSettle(1'b0);
    sclkPeriod(pc, nc, fc, pi, fi);
    assertCount++;
    if (bitCount !== 4'd1) begin
      failCount++;
      $display("[TB] FAIL abort_restart: got bc=%0d, need 1", bitCount);
    end
  endtask

  // sclk rise and cs release arrive together on the 8th bit: cs must win.
  task automatic test_simultaneous();
    int pc, nc, fc, pi, fi, fdSeen;
    for (int k = 0; k < 6; k++) sclkPeriod(pc, nc, fc, pi, fi);
    assertCount++;
    if (bitCount !== 4'd7) begin
      failCount++;
      $display("[TB] FAIL simul_setup: got bc=%0d, need 7", bitCount);
    end
    fdSeen = 0;
    sclkPin = 1'b1; csPin = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (frameDone) fdSeen++;
    end
    sclkPin = 1'b0;
    repeat (10) tick();
    assertCount++;
    if (bitCount !== 4'd0 || fdSeen != 0) begin
      failCount++;
      $display("[TB] FAIL simul_cs_wins: got bc=%0d fd=%0d, need bc=0 fd=0", bitCount, fdSeen);
    end
  endtask

  task automatic test_reset_midframe();
    int pc, nc, fc, pi, fi;
    csSettle(1'b0);
    for (int k = 0; k < 3; k++) sclkPeriod(pc, nc, fc, pi, fi);
    assertCount++;
    if (bitCount !== 4'd3) begin
      failCount++;
      $display("[TB] FAIL midreset_setup: got bc=%0d, need 3", bitCount);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    assertCount++;
    if (bitCount !== 4'd0 || chipSelectConditioned !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_apply: got bc=%0d cs=%b, need bc=0 cs=1",
               bitCount, chipSelectConditioned);
    end
    tick();
    assertCount++;
    if (sClkPosEdge !== 1'b0 || sClkNegEdge !== 1'b0 || frameDone !== 1'b0 ||
        bitCount !== 4'd0 || chipSelectConditioned !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_after: got pe=%b ne=%b fd=%b bc=%0d cs=%b, need 0 0 0 0 1",
               sClkPosEdge, sClkNegEdge, frameDone, bitCount, chipSelectConditioned);
    end
  endtask

  task automatic test_no_overlap();
    assertCount++;
    if (bothCount != 0) begin
      failCount++;
      $display("[TB] FAIL edge_overlap: both pulses high in %0d cycles, need 0", bothCount);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_full_frame();
    test_abort();
    test_simultaneous();
    test_reset_midframe();
    test_no_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
